// File: rtl/bcd_pkg.sv
// Shared constants for the BCD 7-segment display path.
// Segment patterns are active-low, ordered gfedcba.
package bcd_pkg;

  localparam int BCD_DIGITS = 3;

  typedef logic [3:0] nibble_t;
  typedef logic [6:0] seg_t;

  localparam seg_t SEG_0     = 7'h40;
  localparam seg_t SEG_1     = 7'h79;
  localparam seg_t SEG_2     = 7'h24;
  localparam seg_t SEG_3     = 7'h30;
  localparam seg_t SEG_4     = 7'h19;
  localparam seg_t SEG_5     = 7'h12;
  localparam seg_t SEG_6     = 7'h02;
  localparam seg_t SEG_7     = 7'h78;
  localparam seg_t SEG_8     = 7'h00;
  localparam seg_t SEG_9     = 7'h10;
  localparam seg_t SEG_DASH  = 7'h3F;
  localparam seg_t SEG_BLANK = 7'h7F;

endpackage

// File: rtl/seg7_decode.sv
// Combinational nibble to 7-segment pattern; non-decimal nibbles show a dash,
// and blank overrides everything.
module seg7_decode
  import bcd_pkg::*;
(
  input  logic [3:0] nib_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_DASH;
    if (blank_i) begin
      seg_o = SEG_BLANK;
    end else begin
      case (nib_i)
        4'd0:    seg_o = SEG_0;
        4'd1:    seg_o = SEG_1;
        4'd2:    seg_o = SEG_2;
        4'd3:    seg_o = SEG_3;
        4'd4:    seg_o = SEG_4;
        4'd5:    seg_o = SEG_5;
        4'd6:    seg_o = SEG_6;
        4'd7:    seg_o = SEG_7;
        4'd8:    seg_o = SEG_8;
        4'd9:    seg_o = SEG_9;
        default: seg_o = SEG_DASH;
      endcase
    end
  end

endmodule

// File: rtl/bcd_seg_scan.sv
// Time-multiplexed 3-digit common-anode display driver with tear-free value
// updates at frame boundaries and optional leading-zero blanking.
module bcd_seg_scan
  import bcd_pkg::*;
#(
  parameter int CLK_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] bcd_in,
  input  logic        load,
  input  logic        lz_blank,
  output logic [6:0]  seg,
  output logic [2:0]  an,
  output logic        frame_done
);

  localparam int PW = $clog2(CLK_DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);

  localparam logic [1:0] IDX_ONES = 2'd0;
  localparam logic [1:0] IDX_TENS = 2'd1;
  localparam logic [1:0] IDX_HUND = 2'd2;

  logic [PW-1:0] presc_q, presc_d;
  logic [1:0]    idx_q, idx_d;
  logic [11:0]   pend_q, pend_d;
  logic          pend_vld_q, pend_vld_d;
  logic [11:0]   shown_q, shown_d;
  logic [6:0]    seg_q, seg_d;
  logic [2:0]    an_q, an_d;
  logic          frame_done_q;

  logic          tick;
  logic          boundary;
  logic [3:0]    digit;
  logic          digit_blank;
  logic [6:0]    digit_seg;

  assign tick     = (presc_q == PRESC_MAX);
  assign boundary = tick && (idx_q == IDX_HUND);

  always_comb begin
    presc_d    = tick ? '0 : presc_q + 1'b1;
    idx_d      = idx_q;
    if (tick) idx_d = (idx_q == IDX_HUND) ? IDX_ONES : idx_q + 2'd1;

    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    shown_d    = shown_q;
    if (load) begin
      pend_d     = bcd_in;
      pend_vld_d = 1'b1;
    end
    // A load landing on the boundary edge bypasses straight to the display.
    if (boundary) begin
      pend_vld_d = 1'b0;
      if (load)            shown_d = bcd_in;
      else if (pend_vld_q) shown_d = pend_q;
    end
  end

  // Next slot's digit is decoded from next-state values so it lands on the tick edge.
  always_comb begin
    digit       = shown_d[11:8];
    digit_blank = 1'b0;
    case (idx_d)
      IDX_ONES: digit = shown_d[3:0];
      IDX_TENS: begin
        digit       = shown_d[7:4];
        digit_blank = lz_blank && (shown_d[11:8] == 4'd0) && (shown_d[7:4] == 4'd0);
      end
      default: begin
        digit       = shown_d[11:8];
        digit_blank = lz_blank && (shown_d[11:8] == 4'd0);
      end
    endcase
  end

  seg7_decode u_dec (
    .nib_i   (digit),
    .blank_i (digit_blank),
    .seg_o   (digit_seg)
  );

  always_comb begin
    seg_d = seg_q;
    an_d  = an_q;
    if (tick) begin
      seg_d = digit_seg;
      an_d  = ~(3'b001 << idx_d);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q      <= '0;
      idx_q        <= IDX_HUND;
      pend_q       <= '0;
      pend_vld_q   <= 1'b0;
      shown_q      <= '0;
      seg_q        <= SEG_BLANK;
      an_q         <= 3'b111;
      frame_done_q <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      pend_q       <= pend_d;
      pend_vld_q   <= pend_vld_d;
      shown_q      <= shown_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
      frame_done_q <= boundary;
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign frame_done = frame_done_q;

endmodule
